// File: rtl/handshake_coef_arbiter.sv
// ---------------------------------------------------------------------------
// handshake_coef_arbiter
//
// Round-robin arbiter over NUM_REQ valid/ready control channels. Each
// requester carries no data of its own; a granted token is turned into that
// requester's constant coefficient (taken from COEFS) and placed, together
// with the requester index, into a single registered output slot that is
// drained through a valid/ready handshake. A drain and a new load may happen
// in the same cycle, giving one token per cycle sustained throughput.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-low reset
//   ctrl_valid : [NUM_REQ]    per-requester token valid
//   ctrl_ready : [NUM_REQ]    per-requester token accept (combinational)
//   outs       : [DATA_WIDTH] coefficient of the requester owning the slot
//   outs_tag   : [TAG_WIDTH]  index of the requester owning the slot
//   outs_valid : slot holds a token
//   outs_ready : consumer accepts the slot token
// ---------------------------------------------------------------------------
module handshake_coef_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 18,
    parameter int TAG_WIDTH  = 2,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] COEFS =
        {18'h3F800, 18'h00800, 18'h001DD, 18'h3FE23}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [TAG_WIDTH-1:0]  outs_tag,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    // Slot and round-robin pointer state
    logic [DATA_WIDTH-1:0] outs_q, outs_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  ptr_q, ptr_d;

    // Arbitration results
    logic                  found_s;
    int                    dist_s;
    int                    best_s;
    logic [TAG_WIDTH-1:0]  grant_s;
    logic [DATA_WIDTH-1:0] coef_s;
    logic [TAG_WIDTH-1:0]  ptr_nxt_s;
    logic                  loadable_s;
    logic                  xfer_s;

    // Round-robin search: pick the valid requester with the smallest
    // circular distance from ptr_q, so ptr_q itself has top priority.
    always_comb begin
        found_s   = 1'b0;
        dist_s    = 0;
        best_s    = 0;
        grant_s   = '0;
        coef_s    = '0;
        ptr_nxt_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_s = (i >= int'(ptr_q)) ? (i - int'(ptr_q))
                                        : (i + NUM_REQ - int'(ptr_q));
            if (ctrl_valid[i] && (!found_s || (dist_s < best_s))) begin
                found_s   = 1'b1;
                best_s    = dist_s;
                grant_s   = TAG_WIDTH'(i);
                coef_s    = COEFS[i*DATA_WIDTH +: DATA_WIDTH];
                ptr_nxt_s = (i == NUM_REQ - 1) ? '0 : TAG_WIDTH'(i + 1);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Handshake decode; rst gates ctrl_ready so no token is accepted while
    // the block is held in reset.
    always_comb begin
        loadable_s = !valid_q || outs_ready;
        xfer_s     = found_s && loadable_s && rst;
        if (xfer_s) begin
            ctrl_ready = NUM_REQ'(1) << grant_s;
        end else begin
            ctrl_ready = '0;
        end
    end

    // Slot next state: load on transfer, empty on a pure drain, else hold
    always_comb begin
        outs_d  = outs_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer_s) begin
            outs_d  = coef_s;
            tag_d   = grant_s;
            valid_d = 1'b1;
            ptr_d   = ptr_nxt_s;
        end else if (valid_q && outs_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outs_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            outs_q  <= outs_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign outs       = outs_q;
    assign outs_tag   = tag_q;
    assign outs_valid = valid_q;

endmodule

// File: tb/tb_handshake_coef_arbiter.sv
// ---------------------------------------------------------------------------
// tb_handshake_coef_arbiter
//
// Directed bench for handshake_coef_arbiter with default parameters.
// Inputs change 1 time unit after the rising edge; combinational ctrl_ready
// is checked 1 unit later, registered outputs right after each edge.
// ---------------------------------------------------------------------------
module tb_handshake_coef_arbiter;

    localparam logic [17:0] C0 = 18'h3FE23;
    localparam logic [17:0] C1 = 18'h001DD;
    localparam logic [17:0] C2 = 18'h00800;
    localparam logic [17:0] C3 = 18'h3F800;

    logic        clk;
    logic        rst;
    logic [3:0]  ctrl_valid;
    logic [3:0]  ctrl_ready;
    logic [17:0] outs;
    logic [1:0]  outs_tag;
    logic        outs_valid;
    logic        outs_ready;

    int err_cnt;
    int chk_cnt;

    handshake_coef_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .outs       (outs),
        .outs_tag   (outs_tag),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v,
                              input logic [1:0] t, input logic [17:0] c);
        check({tag, ".valid"}, 32'(outs_valid), 32'(v));
        check({tag, ".tag"},   32'(outs_tag),   32'(t));
        check({tag, ".outs"},  32'(outs),       32'(c));
    endtask

    // Drive inputs, let combinational logic settle, then check ctrl_ready
    task automatic drive(input logic [3:0] v, input logic r,
                         input logic [3:0] exp_rdy, input string tag);
        ctrl_valid = v;
        outs_ready = r;
        #1;
        check({tag, ".ready"}, 32'(ctrl_ready), 32'(exp_rdy));
    endtask

    logic [1:0]  seq_tag [8];
    logic [17:0] seq_coef[8];

    initial begin
        err_cnt    = 0;
        chk_cnt    = 0;
        rst        = 1'b0;
        ctrl_valid = 4'b0000;
        outs_ready = 1'b0;
        step();
        step();

        // Reset state, including ctrl_ready held low despite valid requests
        check_slot("reset", 1'b0, 2'd0, 18'h0);
        drive(4'b1111, 1'b1, 4'b0000, "reset_req");
        step();
        check_slot("reset_edge", 1'b0, 2'd0, 18'h0);

        // First grant after reset: requester 0, then ptr=1
        rst = 1'b1;
        drive(4'b0001, 1'b1, 4'b0001, "first");
        step();
        check_slot("first", 1'b1, 2'd0, C0);
        drive(4'b1111, 1'b1, 4'b0010, "ptr_after_first");

        // Restart from a clean reset for the full rotation
        rst = 1'b0;
        #1;
        rst = 1'b1;
        ctrl_valid = 4'b0000;
        outs_ready = 1'b0;
        step();
        check_slot("rst_again", 1'b0, 2'd0, 18'h0);

        // All requesting, consumer always ready: 0,1,2,3,0,1,2,3 back to back
        seq_tag  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        seq_coef = '{C0, C1, C2, C3, C0, C1, C2, C3};
        ctrl_valid = 4'b1111;
        outs_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_slot($sformatf("rr%0d", k), 1'b1, seq_tag[k], seq_coef[k]);
        end
        // ptr is now 0; load requester 1 into the slot
        drive(4'b0010, 1'b1, 4'b0010, "load1");
        step();
        check_slot("load1", 1'b1, 2'd1, C1);

        // Back-pressure: slot stable, no ready for 5 cycles
        for (int k = 0; k < 5; k++) begin
            drive(4'b1101, 1'b0, 4'b0000, $sformatf("stall%0d", k));
            step();
            check_slot($sformatf("stall%0d", k), 1'b1, 2'd1, C1);
        end
        drive(4'b1101, 1'b1, 4'b0100, "unstall");
        step();
        check_slot("unstall", 1'b1, 2'd2, C2);

        // ptr=3 with only 0 and 1 requesting: wrap to 0, then 1
        drive(4'b0011, 1'b1, 4'b0001, "wrap");
        step();
        check_slot("wrap", 1'b1, 2'd0, C0);
        drive(4'b0011, 1'b1, 4'b0010, "after_wrap");
        step();
        check_slot("after_wrap", 1'b1, 2'd1, C1);

        // Drain plus transfer in one cycle: no bubble
        drive(4'b0100, 1'b1, 4'b0100, "drain_xfer");
        step();
        check_slot("drain_xfer", 1'b1, 2'd2, C2);

        // Pure drain: valid drops, data and tag hold
        drive(4'b0000, 1'b1, 4'b0000, "drain");
        step();
        check_slot("drain", 1'b0, 2'd2, C2);

        // Load requester 3, then reset mid-cycle discards it at once
        drive(4'b1000, 1'b0, 4'b1000, "load3");
        step();
        check_slot("load3", 1'b1, 2'd3, C3);
        ctrl_valid = 4'b0000;
        #2;
        rst = 1'b0;
        #1;
        check_slot("async_rst", 1'b0, 2'd0, 18'h0);
        step();
        rst = 1'b1;
        drive(4'b1010, 1'b0, 4'b0010, "post_rst");
        step();
        check_slot("post_rst", 1'b1, 2'd1, C1);

        // Requester withdraws while stalled: nothing is stored for it
        drive(4'b1000, 1'b0, 4'b0000, "withdraw_stall");
        step();
        drive(4'b0000, 1'b1, 4'b0000, "withdraw");
        step();
        check_slot("withdraw", 1'b0, 2'd1, C1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
